// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the call/return and data stack controller:
// request op encodings and controller FSM states.
package stack_ctrl_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // PUSH and CALL both store an entry; POP and RET both remove one.
    function automatic logic is_write_op(input logic [1:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W array with one synchronous write port and one
// registered read port. Contents are intentionally not reset.
module stack_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stack_ctrl.sv
// Call/return and data stack sequencing controller: owns the stack pointer and
// storage, answers each request with a one-cycle response pulse.
// Optional high-water output enabled by defining STACK_CTRL_WATERMARK_EN.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic [1:0]        resp_op,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf_sticky,
    output logic              udf_sticky
`ifdef STACK_CTRL_WATERMARK_EN
    ,
    output logic [CNT_W-1:0]  high_water
`endif
);

    localparam int AW = CNT_W - 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        resp_op_q, resp_op_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              accept;
    logic [CNT_W-1:0]  count_m1;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign req_ready = (state_q == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign count_m1  = count_q - 1'b1;

    stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count_q[AW-1:0]),
        .wdata (req_data),
        .re    (mem_re),
        .raddr (count_m1[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        resp_op_d   = resp_op_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    resp_op_d = req_op;
                    state_d   = S_RESP;
                    if (is_write_op(req_op)) begin
                        resp_data_d = '0;
                        if (full) begin
                            resp_err_d = 1'b1;
                            ovf_d      = 1'b1;
                        end else begin
                            resp_err_d = 1'b0;
                            mem_we     = 1'b1;
                            count_d    = count_q + 1'b1;
                        end
                    end else if (empty) begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                        udf_d       = 1'b1;
                    end else begin
                        // Entry arrives from the registered read port one cycle later.
                        resp_err_d = 1'b0;
                        mem_re     = 1'b1;
                        count_d    = count_m1;
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                resp_data_d = mem_rdata;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush || reset) begin
            state_d = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            mem_we  = 1'b0;
            mem_re  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            resp_op_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            resp_op_q   <= resp_op_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // A flush landing on the response cycle suppresses the pulse.
    assign resp_valid = (state_q == S_RESP) && !flush;
    assign resp_op    = resp_op_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign count      = count_q;
    assign ovf_sticky = ovf_q;
    assign udf_sticky = udf_q;

`ifdef STACK_CTRL_WATERMARK_EN
    logic [CNT_W-1:0] hw_q, hw_d;

    always_comb begin
        hw_d = hw_q;
        if (flush || reset) begin
            hw_d = '0;
        end else if (count_d > hw_q) begin
            hw_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q <= '0;
        end else begin
            hw_q <= hw_d;
        end
    end

    assign high_water = hw_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl; watermark checks are compiled
// in when STACK_CTRL_WATERMARK_EN is defined.
module tb_stack_ctrl;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [1:0]        resp_op;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf_sticky;
    logic              udf_sticky;
`ifdef STACK_CTRL_WATERMARK_EN
    logic [CNT_W-1:0]  high_water;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    int          r_lat;
    logic [1:0]  r_op;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_cnt;
    int          seen;

    stack_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_op    (resp_op),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .ovf_sticky (ovf_sticky),
        .udf_sticky (udf_sticky)
`ifdef STACK_CTRL_WATERMARK_EN
        ,
        .high_water (high_water)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch up to 4 falling edges for its response.
    task automatic xact(input string tag, input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 0;
        for (int i = 1; i <= 4 && r_lat == 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                r_lat  = i;
                r_op   = resp_op;
                r_data = resp_data;
                r_err  = resp_err;
                r_cnt  = 32'(count);
            end
        end
        if (r_lat == 0) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
        end
        $display("[TB] %s op=%0d data=0x%0h -> lat=%0d resp_op=%0d resp_data=0x%0h err=%0d count=%0d",
                 tag, op, d, r_lat, r_op, r_data, r_err, r_cnt);
    endtask

    task automatic expect_resp(input string tag, input int lat, input logic [1:0] op,
                               input logic [31:0] d, input logic err, input int cnt);
        chk({tag, ".lat"},  32'(r_lat), 32'(lat));
        chk({tag, ".op"},   {30'd0, r_op}, {30'd0, op});
        chk({tag, ".data"}, r_data, d);
        chk({tag, ".err"},  {31'd0, r_err}, {31'd0, err});
        chk({tag, ".cnt"},  r_cnt, 32'(cnt));
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        r_op      = 2'b00;
        r_data    = '0;
        r_err     = 1'b0;
        r_cnt     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rop", {30'd0, resp_op}, 32'd0);
        chk("rst.rdata", resp_data, 32'd0);
        chk("rst.rerr", {31'd0, resp_err}, 32'd0);
        chk("rst.empty", {31'd0, empty}, 32'd1);
        chk("rst.full", {31'd0, full}, 32'd0);
        chk("rst.ovf", {31'd0, ovf_sticky}, 32'd0);
        chk("rst.udf", {31'd0, udf_sticky}, 32'd0);

        // CALL / RET
        xact("call", 2'b10, 32'h0000_0040);
        expect_resp("call", 1, 2'b10, 32'd0, 1'b0, 1);
        xact("ret", 2'b11, 32'hFFFF_FFFF);
        expect_resp("ret", 2, 2'b11, 32'h40, 1'b0, 0);

        // LIFO ordering
        xact("push_a", 2'b00, 32'hA);
        expect_resp("push_a", 1, 2'b00, 32'd0, 1'b0, 1);
        xact("push_b", 2'b00, 32'hB);
        xact("push_c", 2'b00, 32'hC);
        expect_resp("push_c", 1, 2'b00, 32'd0, 1'b0, 3);
        xact("pop_c", 2'b01, 32'd0);
        expect_resp("pop_c", 2, 2'b01, 32'hC, 1'b0, 2);
        xact("pop_b", 2'b01, 32'd0);
        expect_resp("pop_b", 2, 2'b01, 32'hB, 1'b0, 1);
        xact("pop_a", 2'b01, 32'd0);
        expect_resp("pop_a", 2, 2'b01, 32'hA, 1'b0, 0);
        chk("lifo.empty", {31'd0, empty}, 32'd1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            xact("fill", 2'b00, 32'h100 + 32'(i));
        end
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.full", {31'd0, full}, 32'd1);
        chk("fill.ovf_pre", {31'd0, ovf_sticky}, 32'd0);
        xact("ovf", 2'b00, 32'hDEAD);
        expect_resp("ovf", 1, 2'b00, 32'd0, 1'b1, 16);
        chk("ovf.sticky", {31'd0, ovf_sticky}, 32'd1);
        xact("ovf_pop", 2'b01, 32'd0);
        expect_resp("ovf_pop", 2, 2'b01, 32'h10F, 1'b0, 15);
        chk("ovf.sticky_hold", {31'd0, ovf_sticky}, 32'd1);
        do_flush();
        chk("flush1.count", 32'(count), 32'd0);
        chk("flush1.ovf", {31'd0, ovf_sticky}, 32'd0);

        // Underflow
        xact("udf", 2'b01, 32'd0);
        expect_resp("udf", 1, 2'b01, 32'd0, 1'b1, 0);
        chk("udf.sticky", {31'd0, udf_sticky}, 32'd1);
        xact("push5", 2'b00, 32'h5);
        expect_resp("push5", 1, 2'b00, 32'd0, 1'b0, 1);
        xact("pop5", 2'b01, 32'd0);
        expect_resp("pop5", 2, 2'b01, 32'h5, 1'b0, 0);

        // Flush during the READ cycle of a POP
        xact("fp1", 2'b00, 32'h11);
        xact("fp2", 2'b00, 32'h22);
        xact("fp3", 2'b00, 32'h33);
        chk("fr.count3", 32'(count), 32'd3);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        @(posedge clk);
        #1 req_valid = 1'b0;
        flush = 1'b1;
        seen = 0;
        @(negedge clk);
        if (resp_valid) seen++;
        @(negedge clk);
        flush = 1'b0;
        chk("fr.count0", 32'(count), 32'd0);
        chk("fr.udf", {31'd0, udf_sticky}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("fr.no_resp", 32'(seen), 32'd0);
        $display("[TB] flush_in_read resp_seen=%0d count=%0d", seen, count);

        // Flush together with a request
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_data  = 32'h77;
        #1;
        chk("fq.ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("fq.no_resp", 32'(seen), 32'd0);
        chk("fq.count", 32'(count), 32'd0);
        $display("[TB] flush_with_req resp_seen=%0d count=%0d", seen, count);

`ifdef STACK_CTRL_WATERMARK_EN
        // High-water mark
        do_flush();
        chk("hw.init", 32'(high_water), 32'd0);
        for (int i = 0; i < 5; i++) begin
            xact("hw_push", 2'b00, 32'h200 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            xact("hw_pop", 2'b01, 32'd0);
        end
        expect_resp("hw_pop3", 2, 2'b01, 32'h202, 1'b0, 2);
        chk("hw.five", 32'(high_water), 32'd5);
        chk("hw.count", 32'(count), 32'd2);
        do_flush();
        chk("hw.flushed", 32'(high_water), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencing controller for the processor's call/return and data stack.
- Accepts CALL, RET, PUSH and POP requests from the execute stage one at a time through a valid/ready handshake.
- Owns the stack pointer and the stack storage; returns popped data (return PC or Rd value) with a response pulse.
- Flags overflow and underflow instead of corrupting state; the execute stage stalls while req_ready is low.

Parameters:
- DEPTH, 16, number of stack entries (power of two, ≥2).
- DATA_W, 32, width of one entry (PC / register width).
- CNT_W, $clog2(DEPTH)+1, width of the entry count, so DEPTH itself is representable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  empties the stack (pipeline flush / exception).
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- req_data  in  DATA_W  Rd value (PUSH) or return address (CALL); ignored for POP/RET.
- resp_valid  out  1  one-cycle response pulse.
- resp_op  out  2  op of the request being answered.
- resp_data  out  DATA_W  popped entry (POP/RET); 0 for PUSH/CALL and errors.
- resp_err  out  1  qualifies resp_valid: request rejected (overflow or underflow).
- count  out  CNT_W  current number of valid entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- ovf_sticky  out  1  set on a rejected PUSH/CALL; cleared only by reset or flush.
- udf_sticky  out  1  set on a rejected POP/RET; cleared only by reset or flush.

Behaviour:
- Reset values: state IDLE, count=0, req_ready=1, resp_valid=0, resp_op=0, resp_data=0, resp_err=0, both sticky flags 0. Storage contents are not reset.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE and only when flush=0. The requester must hold req_op and req_data stable while req_valid is high and not yet accepted.
- FSM states: IDLE, READ, RESP.
- IDLE, accepted PUSH/CALL, not full:
  - Write stack[count] <= req_data; count+1; go to RESP.
  - resp_valid at accept+1 with resp_err=0.
- IDLE, accepted POP/RET, not empty:
  - count-1; issue registered read of address count-1; go to READ.
  - READ -> RESP next cycle; resp_data = entry.
  - resp_valid at accept+2.
- IDLE, accepted PUSH/CALL when full, or POP/RET when empty:
  - No storage or count change; set the matching sticky flag; go to RESP.
  - resp_valid at accept+1 with resp_err=1 and resp_data=0.
- RESP always returns to IDLE; resp_valid is high for exactly one cycle. Maximum throughput is one request per 2 cycles (PUSH) or 3 cycles (POP).
- Pointer arithmetic: count never wraps; the full/empty checks gate every update. Write address = count[CNT_W-2:0].
- PUSH immediately following POP writes to the slot just vacated; the old contents are overwritten.
- Flush: takes priority over everything else.
  - Next cycle: count=0, sticky flags 0, state IDLE.
  - Any in-flight POP/RET or pending response is dropped; no resp_valid is generated.
  - flush and req_valid in the same cycle: the request is not accepted.
- Reset mid-operation behaves like flush and additionally clears resp_* registers.
- empty and full are combinational from count.

Optional Feature:
- Macro: STACK_CTRL_WATERMARK_EN.
- When defined, add output high_water [CNT_W]: the maximum count reached since the last reset or flush. It updates in the same cycle as count and is reset to 0.
- When not defined, the port and register are absent; all other behaviour is identical.

Decomposition:
- Package stack_ctrl_pkg contains:
  - op encoding constants OP_PUSH, OP_POP, OP_CALL, OP_RET;
  - FSM state enum {S_IDLE, S_READ, S_RESP}.
- One sub-module, stack_mem: DEPTH x DATA_W array, one synchronous write port and one registered read port, no reset. stack_ctrl instantiates it and holds all control logic.

Test Plan:
- CALL req_data=0x0000_0040, then RET -> first resp_valid at accept+1, err=0, count=1; RET response at accept+2 with resp_op=11, resp_data=0x40, count=0.
- PUSH 0xA, 0xB, 0xC, then POP×3 -> resp_data 0xC, 0xB, 0xA in order; empty=1 afterwards.
- 16 PUSHes, then a 17th with 0xDEAD -> full=1; 17th response err=1; ovf_sticky=1; count stays 16; next POP returns the 16th value.
- POP on empty -> resp_err=1, resp_data=0, udf_sticky=1, count=0; a following PUSH 0x5 then POP returns 0x5.
- Assert flush in the READ cycle of a POP with count=3 -> no resp_valid, count=0 next cycle; flush together with req_valid -> req_ready=0, request not accepted.
- With STACK_CTRL_WATERMARK_EN: 5 PUSHes, 3 POPs -> high_water=5, count=2; after flush, high_water=0.
